// File: rtl/pl_ddr_pkg.sv
// Shared types, widths and defaults for the PL DDR3 command arbiter.
package pl_ddr_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LEN_W       = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned MAX_LEN_DEF = 32768;
    localparam int unsigned TIMEOUT_DEF = 65535;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4
    } state_e;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } dir_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    // A command is legal when it is non-empty, within the burst limit and word aligned.
    function automatic logic cmd_legal(input logic [ADDR_W-1:0] addr,
                                       input logic [LEN_W-1:0]  len,
                                       input logic [LEN_W-1:0]  max_len);
        return (len != '0) && (len <= max_len) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pl_ddr_arbiter_if.sv
// Requester and DDR-controller signals seen by the arbiter.
interface pl_ddr_arbiter_if;

    logic                               wr_req;
    logic                               rd_req;
    logic [pl_ddr_pkg::ADDR_W-1:0]      wr_addr;
    logic [pl_ddr_pkg::ADDR_W-1:0]      rd_addr;
    logic [pl_ddr_pkg::LEN_W-1:0]       wr_length;
    logic [pl_ddr_pkg::LEN_W-1:0]       rd_length;
    logic                               wr_ack;
    logic                               rd_ack;
    logic                               wr_done;
    logic                               rd_done;
    logic                               pl_ddr_busy;
    logic                               pl_ddr_wr_finish;
    logic                               pl_ddr_rd_finish;
    logic                               pl_ddr_wr_start;
    logic                               pl_ddr_rd_start;
    logic [pl_ddr_pkg::ADDR_W-1:0]      pl_ddr_wr_addr;
    logic [pl_ddr_pkg::ADDR_W-1:0]      pl_ddr_rd_addr;
    logic [pl_ddr_pkg::LEN_W-1:0]       pl_ddr_wr_length;
    logic [pl_ddr_pkg::LEN_W-1:0]       pl_ddr_rd_length;
    logic                               err_len;
    logic                               err_timeout;
    logic [pl_ddr_pkg::STATE_W-1:0]     state_out;

    // Arbiter side.
    modport slave (
        input  wr_req, rd_req, wr_addr, rd_addr, wr_length, rd_length,
        input  pl_ddr_busy, pl_ddr_wr_finish, pl_ddr_rd_finish,
        output wr_ack, rd_ack, wr_done, rd_done,
        output pl_ddr_wr_start, pl_ddr_rd_start,
        output pl_ddr_wr_addr, pl_ddr_rd_addr, pl_ddr_wr_length, pl_ddr_rd_length,
        output err_len, err_timeout, state_out
    );

    // Requester / controller side.
    modport master (
        output wr_req, rd_req, wr_addr, rd_addr, wr_length, rd_length,
        output pl_ddr_busy, pl_ddr_wr_finish, pl_ddr_rd_finish,
        input  wr_ack, rd_ack, wr_done, rd_done,
        input  pl_ddr_wr_start, pl_ddr_rd_start,
        input  pl_ddr_wr_addr, pl_ddr_rd_addr, pl_ddr_wr_length, pl_ddr_rd_length,
        input  err_len, err_timeout, state_out
    );

endinterface

// File: rtl/pl_ddr_arbiter.sv
// Round-robin write/read arbiter issuing one command at a time to the PL DDR3 controller.
module pl_ddr_arbiter
    import pl_ddr_pkg::*;
#(
    parameter int unsigned MAX_LEN        = MAX_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              pl_clk,
    input  logic              rst,
    pl_ddr_arbiter_if.slave   bus
);

    state_e           state_q, state_d;
    dir_e             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             wr_cmd_q, wr_cmd_d;
    cmd_t             rd_cmd_q, rd_cmd_d;
    logic             wr_ack_q, wr_ack_d;
    logic             rd_ack_q, rd_ack_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_done_q, rd_done_d;
    logic             wr_start_q, wr_start_d;
    logic             rd_start_q, rd_start_d;
    logic             err_len_q, err_len_d;
    logic             err_to_q, err_to_d;
    logic             wait_expired_c;

    // WAIT has run its full budget once this edge would be its TIMEOUT_CYCLES-th.
    assign wait_expired_c = (32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES);

    // State register and registered outputs.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= DIR_RD;
            cnt_q      <= '0;
            wr_cmd_q   <= '0;
            rd_cmd_q   <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wr_cmd_q   <= wr_cmd_d;
            rd_cmd_q   <= rd_cmd_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
        end
    end

    // Next-state, grant, command and completion logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = '0;
        wr_cmd_d   = wr_cmd_q;
        rd_cmd_d   = rd_cmd_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;
        err_len_d  = 1'b0;
        err_to_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.pl_ddr_busy) begin
                    if (bus.wr_req && (!bus.rd_req || last_q == DIR_RD)) begin
                        wr_ack_d = 1'b1;
                        last_d   = DIR_WR;
                        if (cmd_legal(bus.wr_addr, bus.wr_length, LEN_W'(MAX_LEN))) begin
                            wr_cmd_d = '{addr: bus.wr_addr, len: bus.wr_length};
                            state_d  = ST_WR_ISSUE;
                        end else begin
                            err_len_d = 1'b1;
                        end
                    end else if (bus.rd_req) begin
                        rd_ack_d = 1'b1;
                        last_d   = DIR_RD;
                        if (cmd_legal(bus.rd_addr, bus.rd_length, LEN_W'(MAX_LEN))) begin
                            rd_cmd_d = '{addr: bus.rd_addr, len: bus.rd_length};
                            state_d  = ST_RD_ISSUE;
                        end else begin
                            err_len_d = 1'b1;
                        end
                    end
                end
            end
            ST_WR_ISSUE: begin
                wr_start_d = 1'b1;
                state_d    = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (bus.pl_ddr_wr_finish) begin
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_expired_c) begin
                    wr_done_d = 1'b1;
                    err_to_d  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_ISSUE: begin
                rd_start_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.pl_ddr_rd_finish) begin
                    rd_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_expired_c) begin
                    rd_done_d = 1'b1;
                    err_to_d  = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wr_ack           = wr_ack_q;
    assign bus.rd_ack           = rd_ack_q;
    assign bus.wr_done          = wr_done_q;
    assign bus.rd_done          = rd_done_q;
    assign bus.pl_ddr_wr_start  = wr_start_q;
    assign bus.pl_ddr_rd_start  = rd_start_q;
    assign bus.pl_ddr_wr_addr   = wr_cmd_q.addr;
    assign bus.pl_ddr_wr_length = wr_cmd_q.len;
    assign bus.pl_ddr_rd_addr   = rd_cmd_q.addr;
    assign bus.pl_ddr_rd_length = rd_cmd_q.len;
    assign bus.err_len          = err_len_q;
    assign bus.err_timeout      = err_to_q;
    assign bus.state_out        = state_q;

endmodule
